// File: rtl/munoc_check_session_ctrl_if.sv
// Control/status bundle between the register front end, the stream checker
// and the session controller.
interface munoc_check_session_ctrl_if #(
    parameter int unsigned BW_COUNT   = 16,
    parameter int unsigned BW_TIMEOUT = 16
);
    logic                  cfg_start;
    logic                  cfg_abort;
    logic [BW_COUNT-1:0]   cfg_num_match;
    logic [BW_TIMEOUT-1:0] cfg_timeout;
    logic                  chk_match;
    logic                  chk_error;
    logic                  chk_enable;
    logic                  chk_reset;
    logic                  busy;
    logic                  done;
    logic                  pass;
    logic                  fail_mismatch;
    logic                  fail_timeout;
    logic                  aborted;
    logic [BW_COUNT-1:0]   match_count;

    modport master (
        output cfg_start, cfg_abort, cfg_num_match, cfg_timeout, chk_match, chk_error,
        input  chk_enable, chk_reset, busy, done, pass, fail_mismatch, fail_timeout,
               aborted, match_count
    );

    modport slave (
        input  cfg_start, cfg_abort, cfg_num_match, cfg_timeout, chk_match, chk_error,
        output chk_enable, chk_reset, busy, done, pass, fail_mismatch, fail_timeout,
               aborted, match_count
    );
endinterface

// File: rtl/munoc_check_session_ctrl.sv
// Session sequencer for the NoC stream checker: clear, run, count matched pops,
// watch for stalls and report pass / mismatch / timeout / aborted.
module munoc_check_session_ctrl #(
    parameter int unsigned BW_COUNT     = 16,
    parameter int unsigned BW_TIMEOUT   = 16,
    parameter int unsigned CLEAR_CYCLES = 2
) (
    input logic                       clk,
    input logic                       rst,
    munoc_check_session_ctrl_if.slave bus
);
    localparam int unsigned CW = (CLEAR_CYCLES > 1) ? $clog2(CLEAR_CYCLES) : 1;
    localparam logic [CW-1:0]         CLR_LAST = CW'(CLEAR_CYCLES - 1);
    localparam logic [CW-1:0]         CLR_ONE  = CW'(1);
    localparam logic [BW_COUNT-1:0]   CNT_ONE  = BW_COUNT'(1);
    localparam logic [BW_TIMEOUT-1:0] TO_ONE   = BW_TIMEOUT'(1);

    typedef enum logic [1:0] {IDLE, CLEAR, RUN} state_t;

    state_t                state_q, state_d;
    logic [CW-1:0]         clr_cnt_q, clr_cnt_d;
    logic [BW_COUNT-1:0]   target_q, target_d;
    logic [BW_TIMEOUT-1:0] timeout_q, timeout_d;
    logic [BW_TIMEOUT-1:0] stall_q, stall_d;
    logic [BW_COUNT-1:0]   mcount_q, mcount_d;
    logic                  chk_enable_q, chk_enable_d;
    logic                  chk_reset_q, chk_reset_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  pass_q, pass_d;
    logic                  mism_q, mism_d;
    logic                  tout_q, tout_d;
    logic                  abrt_q, abrt_d;
    logic                  finish;
    logic [BW_COUNT-1:0]   mcount_inc;
    logic [BW_TIMEOUT-1:0] stall_last;

    assign mcount_inc = mcount_q + CNT_ONE;
    assign stall_last = timeout_q - TO_ONE;

    always_comb begin
        state_d      = state_q;
        clr_cnt_d    = clr_cnt_q;
        target_d     = target_q;
        timeout_d    = timeout_q;
        stall_d      = stall_q;
        mcount_d     = mcount_q;
        chk_enable_d = chk_enable_q;
        chk_reset_d  = chk_reset_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
        pass_d       = pass_q;
        mism_d       = mism_q;
        tout_d       = tout_q;
        abrt_d       = abrt_q;
        finish       = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (bus.cfg_start) begin
                    state_d     = CLEAR;
                    clr_cnt_d   = '0;
                    target_d    = bus.cfg_num_match;
                    timeout_d   = bus.cfg_timeout;
                    stall_d     = '0;
                    mcount_d    = '0;
                    pass_d      = 1'b0;
                    mism_d      = 1'b0;
                    tout_d      = 1'b0;
                    abrt_d      = 1'b0;
                    busy_d      = 1'b1;
                    chk_reset_d = 1'b1;
                end
            end
            CLEAR: begin
                if (bus.cfg_abort) begin
                    abrt_d = 1'b1;
                    finish = 1'b1;
                end else if (clr_cnt_q == CLR_LAST) begin
                    if (target_q == '0) begin
                        pass_d = 1'b1;
                        finish = 1'b1;
                    end else begin
                        state_d      = RUN;
                        chk_reset_d  = 1'b0;
                        chk_enable_d = 1'b1;
                    end
                end else begin
                    clr_cnt_d = clr_cnt_q + CLR_ONE;
                end
            end
            RUN: begin
                // Stall counter saturates at timeout-1; with timeout 0 it just sticks at all-ones.
                if (bus.chk_match) begin
                    mcount_d = mcount_inc;
                    stall_d  = '0;
                end else if (stall_q != stall_last) begin
                    stall_d = stall_q + TO_ONE;
                end

                if (bus.cfg_abort) begin
                    abrt_d = 1'b1;
                    finish = 1'b1;
                end else if (bus.chk_error) begin
                    mism_d = 1'b1;
                    finish = 1'b1;
                end else if (bus.chk_match && (mcount_inc == target_q)) begin
                    pass_d = 1'b1;
                    finish = 1'b1;
                end else if ((timeout_q != '0) && !bus.chk_match && (stall_q == stall_last)) begin
                    tout_d = 1'b1;
                    finish = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (finish) begin
            state_d      = IDLE;
            busy_d       = 1'b0;
            chk_enable_d = 1'b0;
            chk_reset_d  = 1'b0;
            done_d       = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            clr_cnt_q    <= '0;
            target_q     <= '0;
            timeout_q    <= '0;
            stall_q      <= '0;
            mcount_q     <= '0;
            chk_enable_q <= 1'b0;
            chk_reset_q  <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            pass_q       <= 1'b0;
            mism_q       <= 1'b0;
            tout_q       <= 1'b0;
            abrt_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            clr_cnt_q    <= clr_cnt_d;
            target_q     <= target_d;
            timeout_q    <= timeout_d;
            stall_q      <= stall_d;
            mcount_q     <= mcount_d;
            chk_enable_q <= chk_enable_d;
            chk_reset_q  <= chk_reset_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            pass_q       <= pass_d;
            mism_q       <= mism_d;
            tout_q       <= tout_d;
            abrt_q       <= abrt_d;
        end
    end

    assign bus.chk_enable    = chk_enable_q;
    assign bus.chk_reset     = chk_reset_q;
    assign bus.busy          = busy_q;
    assign bus.done          = done_q;
    assign bus.pass          = pass_q;
    assign bus.fail_mismatch = mism_q;
    assign bus.fail_timeout  = tout_q;
    assign bus.aborted       = abrt_q;
    assign bus.match_count   = mcount_q;
endmodule

// File: tb/tb_munoc_check_session_ctrl.sv
// Directed bench for munoc_check_session_ctrl; inputs change and outputs are
// sampled on the falling edge, the DUT acts on the rising edge.
module tb_munoc_check_session_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    always #5 clk = ~clk;

    munoc_check_session_ctrl_if #(.BW_COUNT(16), .BW_TIMEOUT(16)) bus ();

    munoc_check_session_ctrl #(
        .BW_COUNT    (16),
        .BW_TIMEOUT  (16),
        .CLEAR_CYCLES(2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic nc(input int unsigned n);
        repeat (n) @(negedge clk);
    endtask

    task automatic start(input logic [15:0] tgt, input logic [15:0] to);
        bus.cfg_start     = 1'b1;
        bus.cfg_num_match = tgt;
        bus.cfg_timeout   = to;
        nc(1);
        bus.cfg_start = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".enable"}, {31'd0, bus.chk_enable}, 32'd0);
        check({tag, ".reset"},  {31'd0, bus.chk_reset}, 32'd0);
        check({tag, ".busy"},   {31'd0, bus.busy}, 32'd0);
        check({tag, ".done"},   {31'd0, bus.done}, 32'd0);
        check({tag, ".flags"},  {28'd0, bus.pass, bus.fail_mismatch, bus.fail_timeout, bus.aborted}, 32'd0);
        check({tag, ".count"},  {16'd0, bus.match_count}, 32'd0);
    endtask

    initial begin
        bus.cfg_start     = 1'b0;
        bus.cfg_abort     = 1'b0;
        bus.cfg_num_match = '0;
        bus.cfg_timeout   = '0;
        bus.chk_match     = 1'b0;
        bus.chk_error     = 1'b0;

        nc(2);
        check_all_zero("reset");
        rst = 1'b0;
        nc(1);

        // target=4, no timeout, matches in RUN cycles 1,3,4,7
        start(16'd4, 16'd0);
        check("t1.clr1.reset",  {31'd0, bus.chk_reset}, 32'd1);
        check("t1.clr1.busy",   {31'd0, bus.busy}, 32'd1);
        check("t1.clr1.enable", {31'd0, bus.chk_enable}, 32'd0);
        nc(1);
        check("t1.clr2.reset",  {31'd0, bus.chk_reset}, 32'd1);
        check("t1.clr2.enable", {31'd0, bus.chk_enable}, 32'd0);
        nc(1);
        check("t1.run.reset",   {31'd0, bus.chk_reset}, 32'd0);
        check("t1.run.enable",  {31'd0, bus.chk_enable}, 32'd1);
        bus.chk_match = 1'b1; nc(1);
        bus.chk_match = 1'b0;
        check("t1.count1", {16'd0, bus.match_count}, 32'd1);
        nc(1);
        bus.chk_match = 1'b1; nc(2);
        bus.chk_match = 1'b0;
        check("t1.count3", {16'd0, bus.match_count}, 32'd3);
        check("t1.nodone", {31'd0, bus.done}, 32'd0);
        nc(2);
        bus.chk_match = 1'b1; nc(1);
        bus.chk_match = 1'b0;
        check("t1.done",   {31'd0, bus.done}, 32'd1);
        check("t1.pass",   {31'd0, bus.pass}, 32'd1);
        check("t1.count4", {16'd0, bus.match_count}, 32'd4);
        check("t1.busy",   {31'd0, bus.busy}, 32'd0);
        check("t1.enable", {31'd0, bus.chk_enable}, 32'd0);
        nc(1);
        check("t1.done1cyc", {31'd0, bus.done}, 32'd0);
        check("t1.passheld", {31'd0, bus.pass}, 32'd1);

        // target=8, error after 2 matches; error during CLEAR must be ignored
        start(16'd8, 16'd0);
        check("t2.passcleared", {31'd0, bus.pass}, 32'd0);
        bus.chk_error = 1'b1; nc(1);
        bus.chk_error = 1'b0; nc(1);
        check("t2.clrerr.enable", {31'd0, bus.chk_enable}, 32'd1);
        check("t2.clrerr.mism",   {31'd0, bus.fail_mismatch}, 32'd0);
        bus.chk_match = 1'b1; nc(2);
        bus.chk_match = 1'b0;
        bus.chk_error = 1'b1; nc(1);
        bus.chk_error = 1'b0;
        check("t2.mism",   {31'd0, bus.fail_mismatch}, 32'd1);
        check("t2.done",   {31'd0, bus.done}, 32'd1);
        check("t2.count",  {16'd0, bus.match_count}, 32'd2);
        check("t2.enable", {31'd0, bus.chk_enable}, 32'd0);
        check("t2.pass",   {31'd0, bus.pass}, 32'd0);
        nc(1);
        check("t2.done1cyc", {31'd0, bus.done}, 32'd0);

        // target=8, timeout=5; one match then silence
        start(16'd8, 16'd5);
        check("t3.mismcleared", {31'd0, bus.fail_mismatch}, 32'd0);
        nc(2);
        bus.chk_match = 1'b1; nc(1);
        bus.chk_match = 1'b0;
        nc(4);
        check("t3.notyet", {31'd0, bus.fail_timeout}, 32'd0);
        check("t3.busy",   {31'd0, bus.busy}, 32'd1);
        nc(1);
        check("t3.tout",  {31'd0, bus.fail_timeout}, 32'd1);
        check("t3.done",  {31'd0, bus.done}, 32'd1);
        check("t3.count", {16'd0, bus.match_count}, 32'd1);
        nc(1);

        // target=3; error together with final match
        start(16'd3, 16'd0);
        check("t4.toutcleared", {31'd0, bus.fail_timeout}, 32'd0);
        nc(2);
        bus.chk_match = 1'b1; nc(2);
        bus.chk_error = 1'b1; nc(1);
        bus.chk_match = 1'b0;
        bus.chk_error = 1'b0;
        check("t4.mism", {31'd0, bus.fail_mismatch}, 32'd1);
        check("t4.pass", {31'd0, bus.pass}, 32'd0);
        check("t4.done", {31'd0, bus.done}, 32'd1);
        nc(1);

        // target=0; second start while busy ignored
        start(16'd0, 16'd0);
        bus.cfg_start = 1'b1;
        check("t5.busy", {31'd0, bus.busy}, 32'd1);
        nc(1);
        bus.cfg_start = 1'b0;
        check("t5.nodone", {31'd0, bus.done}, 32'd0);
        check("t5.enable0", {31'd0, bus.chk_enable}, 32'd0);
        nc(1);
        check("t5.done",   {31'd0, bus.done}, 32'd1);
        check("t5.pass",   {31'd0, bus.pass}, 32'd1);
        check("t5.busy0",  {31'd0, bus.busy}, 32'd0);
        check("t5.enable", {31'd0, bus.chk_enable}, 32'd0);
        check("t5.reset",  {31'd0, bus.chk_reset}, 32'd0);
        nc(1);
        check("t5.noreclr", {31'd0, bus.chk_reset}, 32'd0);
        check("t5.idle",    {31'd0, bus.busy}, 32'd0);

        // target=10; abort in RUN, then abort in IDLE has no effect
        start(16'd10, 16'd0);
        nc(2);
        bus.chk_match = 1'b1; nc(2);
        bus.chk_match = 1'b0;
        bus.cfg_abort = 1'b1; nc(1);
        bus.cfg_abort = 1'b0;
        check("t6a.aborted", {31'd0, bus.aborted}, 32'd1);
        check("t6a.done",    {31'd0, bus.done}, 32'd1);
        check("t6a.count",   {16'd0, bus.match_count}, 32'd2);
        check("t6a.enable",  {31'd0, bus.chk_enable}, 32'd0);
        bus.cfg_abort = 1'b1; nc(1);
        bus.cfg_abort = 1'b0;
        check("t6a.idleabort.busy", {31'd0, bus.busy}, 32'd0);
        check("t6a.idleabort.done", {31'd0, bus.done}, 32'd0);
        check("t6a.countheld",      {16'd0, bus.match_count}, 32'd2);

        // abort during CLEAR
        start(16'd10, 16'd0);
        check("t6b.reset1", {31'd0, bus.chk_reset}, 32'd1);
        bus.cfg_abort = 1'b1; nc(1);
        bus.cfg_abort = 1'b0;
        check("t6b.aborted", {31'd0, bus.aborted}, 32'd1);
        check("t6b.reset0",  {31'd0, bus.chk_reset}, 32'd0);
        check("t6b.done",    {31'd0, bus.done}, 32'd1);
        check("t6b.enable",  {31'd0, bus.chk_enable}, 32'd0);
        nc(1);

        // asynchronous reset mid-RUN
        start(16'd10, 16'd0);
        nc(2);
        bus.chk_match = 1'b1; nc(1);
        bus.chk_match = 1'b0;
        check("t6c.count", {16'd0, bus.match_count}, 32'd1);
        #2 rst = 1'b1;
        #1 check_all_zero("t6c.async");
        nc(1);
        rst = 1'b0;
        nc(1);
        check_all_zero("t6c.after");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
